seq_div: RTL
============

Name: seq_div

Overview:
- Multi-cycle signed restoring divider for the CPU's DIV instruction; the subtractive counterpart of the existing carry-lookahead adder datapath.
- Performs one shift-and-subtract step per clock.
- Delivers quotient (to LO) and remainder (to HI) with a start/done handshake to the control unit.
- Sits beside the ALU; the control unit stalls on busy.

Parameters:
- WIDTH, 32, operand/result width in bits (must be a multiple of 4, min 8).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- start  in  1  begin division; operands sampled on the same edge.
- dividend  in  WIDTH  signed two's complement dividend.
- divisor  in  WIDTH  signed two's complement divisor.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; results valid and held afterwards.
- quotient  out  WIDTH  signed quotient, truncated toward zero.
- remainder  out  WIDTH  signed remainder; takes the sign of the dividend.
- div_by_zero  out  1  set with done when divisor was 0; held with results.

Interface (already decided): one clock, clk; reset clr is synchronous and active-high.

Behaviour:
- Reset: state IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0.
- clr overrides everything, including mid-operation: next edge returns to IDLE with all outputs 0. No partial result is ever exposed.
- start is accepted only in IDLE or DONE. It is ignored while busy.
- start asserted in the DONE cycle is accepted, and done falls.
- States and transitions:
  - IDLE -> SETUP on start. Latch sign flags and the zero-divisor flag.
  - SETUP (1 cycle): A = 0, Q = |dividend|, M = |divisor|, counter = WIDTH-1.
  - ITER (WIDTH cycles): shift {A,Q} left by 1. Trial T = A - M, computed WIDTH+1 bits wide. If T >= 0, then A = T and Q[0] = 1; else Q[0] = 0. Decrement the counter; on 0 go to FIX.
  - FIX (1 cycle): negate Q if the operand signs differ; negate A if the dividend is negative. Register to quotient/remainder.
  - DONE: done = 1 for exactly one cycle, then IDLE unless a new start arrives. busy = 0 in DONE.
- Latency: start sampled at edge t; done is high during cycle t+WIDTH+3 (35 for WIDTH=32).
- Results: quotient, remainder and div_by_zero change only on the FIX edge or on clr. They are stable in all other cycles.
- Overflow: most-negative / -1 gives quotient = most-negative (wraps), remainder 0, no flag. Absolute value of most-negative is handled as an unsigned WIDTH-bit magnitude.
- Divisor zero: quotient = all ones, remainder = dividend (unmodified), div_by_zero = 1. The FIX stage forces these values regardless of iteration contents.
- Dividend 0: quotient 0, remainder 0, full latency.

Optional Feature:
- Macro SEQ_DIV_ZERO_FAST_EN.
- Defined: a zero divisor detected at start goes IDLE -> FIX directly, skipping SETUP/ITER. done is high in cycle t+2, with the same result values as above.
- Undefined: a zero divisor takes the full WIDTH+3 latency. Latency is then data-independent.

Decomposition:
- Shared package div_pkg holds:
  - state encoding constants (IDLE, SETUP, ITER, FIX, DONE);
  - counter width localparam (clog2 of WIDTH);
  - zero-divisor result constants.
- One sub-module: sub_stage. It is a WIDTH+1-bit two's-complement subtractor (A + ~M + 1) built from the team's 4-bit lookahead adder slices. It outputs difference and sign. Control FSM and registers stay in seq_div.

Test Plan:
- 100 / 7 -> quotient 14, remainder 2, div_by_zero 0, done exactly at cycle t+35, busy high cycles t+1..t+34.
- -100 / 7 -> quotient -14 (0xFFFFFFF2), remainder -2 (0xFFFFFFFE). Also 100 / -7 -> quotient -14, remainder 2.
- 5 / 0 -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1. done at t+35, or t+2 with SEQ_DIV_ZERO_FAST_EN.
- 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Also 0x80000000 / 2 -> quotient 0xC0000000, remainder 0.
- Start 1000 / 3; pulse start again with 9 / 3 at cycle t+10 (ignored), giving 333 rem 1. Then start 9 / 3 in the DONE cycle -> accepted, result 3 rem 0 at +35 cycles.
- Start 1000 / 3; assert clr at cycle t+12 -> next edge busy 0, done 0, outputs 0. No done pulse follows; a subsequent start works normally.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding, counter sizing and zero-divisor constants for seq_div
package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } div_state_e;

  localparam int DIV_WIDTH_DEF = 32;

  // Quotient fill bit and flag value reported for a zero divisor.
  localparam logic DIV0_Q_BIT = 1'b1;
  localparam logic DIV0_FLAG  = 1'b1;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/seq_div_sub_stage.sv
// rtl/seq_div_sub_stage.sv - WIDTH+1 bit trial subtractor a + ~m + 1 from 4-bit lookahead slices
module sub_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH-1:0] diff,
  output logic             neg
);

  localparam int NS = WIDTH / 4;

  logic [WIDTH:0]   b;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] sum;
  logic [NS:0]      c;
  logic [3:0]       gs;
  logic [3:0]       ps;
  logic [3:0]       cc;

  assign b = ~m;
  assign g = a[WIDTH-1:0] & b[WIDTH-1:0];
  assign p = a[WIDTH-1:0] ^ b[WIDTH-1:0];

  always_comb begin
    c    = '0;
    gs   = '0;
    ps   = '0;
    cc   = '0;
    sum  = '0;
    c[0] = 1'b1;
    for (int s = 0; s < NS; s++) begin
      gs     = g[4*s +: 4];
      ps     = p[4*s +: 4];
      cc[0]  = c[s];
      cc[1]  = gs[0] | (ps[0] & c[s]);
      cc[2]  = gs[1] | (ps[1] & gs[0]) | (ps[1] & ps[0] & c[s]);
      cc[3]  = gs[2] | (ps[2] & gs[1]) | (ps[2] & ps[1] & gs[0]) | (ps[2] & ps[1] & ps[0] & c[s]);
      c[s+1] = gs[3] | (ps[3] & gs[2]) | (ps[3] & ps[2] & gs[1]) |
               (ps[3] & ps[2] & ps[1] & gs[0]) | ((&ps) & c[s]);
      sum[4*s +: 4] = ps ^ cc;
    end
  end

  // The extra top bit only carries the sign of the trial difference.
  assign diff = sum;
  assign neg  = a[WIDTH] ^ b[WIDTH] ^ c[NS];

endmodule

// File: rtl/seq_div.sv
// rtl/seq_div.sv - signed restoring divider, one shift-and-subtract step per clock
// SEQ_DIV_ZERO_FAST_EN: a zero divisor jumps from start straight to FIX.
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dsr_neg_q, dsr_neg_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH-1:0] t_diff;
  logic             t_neg;

  assign a_shift = {a_q, q_q[WIDTH-1]};

  sub_stage #(.WIDTH(WIDTH)) u_sub (
    .a    (a_shift),
    .m    ({1'b0, m_q}),
    .diff (t_diff),
    .neg  (t_neg)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    dvd_d     = dvd_q;
    cnt_d     = cnt_q;
    dsr_neg_d = dsr_neg_q;
    div0_d    = div0_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dvd_d     = dividend;
          m_d       = divisor;
          dsr_neg_d = divisor[WIDTH-1];
          div0_d    = (divisor == '0);
`ifdef SEQ_DIV_ZERO_FAST_EN
          state_d   = (divisor == '0) ? S_FIX : S_SETUP;
`else
          state_d   = S_SETUP;
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        // Magnitudes are unsigned, so the most-negative value maps to itself correctly.
        a_d     = '0;
        q_d     = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
        m_d     = dsr_neg_q ? -m_q : m_q;
        cnt_d   = CW'(WIDTH - 1);
        state_d = S_ITER;
      end
      S_ITER: begin
        a_d = t_neg ? a_shift[WIDTH-1:0] : t_diff;
        q_d = {q_q[WIDTH-2:0], ~t_neg};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        if (div0_q) begin
          quo_d = {WIDTH{DIV0_Q_BIT}};
          rem_d = dvd_q;
          dbz_d = DIV0_FLAG;
        end else begin
          quo_d = (dvd_q[WIDTH-1] ^ dsr_neg_q) ? -q_q : q_q;
          rem_d = dvd_q[WIDTH-1] ? -a_q : a_q;
          dbz_d = 1'b0;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      dvd_q     <= '0;
      cnt_q     <= '0;
      dsr_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      dvd_q     <= dvd_d;
      cnt_q     <= cnt_d;
      dsr_neg_q <= dsr_neg_d;
      div0_q    <= div0_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q == S_SETUP) || (state_q == S_ITER) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
